// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Turns one debounced key level into single-cycle event pulses:
//   press edge, short press, long press and (optionally) auto-repeat.
//   Optional feature macro: KEY_REPEAT_EN
//     defined   - periodic repeat_pulse while the key stays held after long_pulse
//     undefined - repeat_pulse is constant 0 and HELD only waits for release
//   All pulses are registered and exactly one clk wide. A shared hold counter
//   is cleared on every state change, so it never wraps.

module key_event_decoder #(
  parameter logic        PRESS_LEVEL = 1'b1,
  parameter int unsigned LONG_CNT    = 32'd50_000_000,
  parameter int unsigned REPEAT_CNT  = 32'd10_000_000,
  parameter int unsigned CNT_W       = 32'd32
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_down,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } state_t;

  // Last count value before the long / repeat event fires.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 32'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             key_d;
  logic             act;
  logic             cnt_at_limit;
  logic             press_next;
  logic             short_next;
  logic             long_next;
  logic             repeat_next;

  assign act = (key_in == PRESS_LEVEL);

  // One comparator serves both phases: LONG limit while PRESSED, REPEAT limit while HELD.
  assign cnt_at_limit = (hold_cnt == ((state == HELD) ? REPEAT_LAST : LONG_LAST));

  // key_d is a flop; the compare against a constant reduces to a buffer or inverter.
  assign key_down = (key_d == PRESS_LEVEL);

  // Next-state, next-count and next-pulse decode; release always wins over a coincident limit.
  always_comb begin
    state_next  = state;
    cnt_next    = hold_cnt;
    press_next  = 1'b0;
    short_next  = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = CNT_ZERO;
        if (act) begin
          state_next = PRESSED;
          press_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      PRESSED: begin
        if (!act) begin
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
          short_next = 1'b1;
        end else if (cnt_at_limit) begin
          state_next = HELD;
          cnt_next   = CNT_ZERO;
          long_next  = 1'b1;
        end else begin
          cnt_next = hold_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!act) begin
          // A long press ends silently: no short_pulse after long_pulse.
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
        end else begin
`ifdef KEY_REPEAT_EN
          if (cnt_at_limit) begin
            cnt_next    = CNT_ZERO;
            repeat_next = 1'b1;
          end else begin
            cnt_next = hold_cnt + CNT_ONE;
          end
`else
          cnt_next = CNT_ZERO;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, key copy and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hold_cnt     <= CNT_ZERO;
      key_d        <= ~PRESS_LEVEL;
      press_pulse  <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= cnt_next;
      key_d        <= key_in;
      press_pulse  <= press_next;
      short_pulse  <= short_next;
      long_pulse   <= long_next;
      repeat_pulse <= repeat_next;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder (PRESS_LEVEL=1, LONG_CNT=10, REPEAT_CNT=4).
// A directed prefix covers reset, short/long press, the LONG boundary and
// reset mid-hold; a random key/reset pattern follows. The reference model
// works from elapsed time since the accepted press, and follows KEY_REPEAT_EN.

module tb_key_event_decoder;

  localparam int LONG_CNT   = 10;
  localparam int REPEAT_CNT = 4;

  logic clk;
  logic reset;
  logic key_in;
  logic key_down;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;

  int n_checks;
  int n_fails;
  int cyc;

  bit key_q[$];
  bit rst_q[$];

  key_event_decoder #(
    .PRESS_LEVEL (1'b1),
    .LONG_CNT    (LONG_CNT),
    .REPEAT_CNT  (REPEAT_CNT),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .key_down     (key_down),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic add(input int n, input bit k, input bit r);
    for (int i = 0; i < n; i++) begin
      key_q.push_back(k);
      rst_q.push_back(r);
    end
  endtask

  // Reference model state: edge index of the accepted press, -1 when none.
  int press_start;
  int cnt_press, cnt_short, cnt_long, cnt_repeat;
  int dut_press, dut_short, dut_long, dut_repeat;

  initial begin
    logic [4:0] exp_v;
    logic [4:0] obs_v;
    int h;
    int hi_len;

    n_checks = 0;
    n_fails  = 0;
    cyc      = 0;
    press_start = -1;
    cnt_press = 0; cnt_short = 0; cnt_long = 0; cnt_repeat = 0;
    dut_press = 0; dut_short = 0; dut_long = 0; dut_repeat = 0;
    reset  = 1'b0;
    key_in = 1'b0;

    // Reset held with key pressed, then released: fresh press.
    add(3, 1'b1, 1'b0); add(4, 1'b1, 1'b1); add(3, 1'b0, 1'b1);
    // Short press, 5 cycles.
    add(5, 1'b1, 1'b1); add(3, 1'b0, 1'b1);
    // Long hold, 30 cycles (repeats when enabled).
    add(30, 1'b1, 1'b1); add(3, 1'b0, 1'b1);
    // LONG boundary: 10 cycles -> short, 11 -> long; then back-to-back press.
    add(10, 1'b1, 1'b1); add(2, 1'b0, 1'b1);
    add(11, 1'b1, 1'b1); add(1, 1'b0, 1'b1);
    add(3, 1'b1, 1'b1);  add(2, 1'b0, 1'b1);
    // Reset at press+6 for 2 cycles with key held, then continue holding.
    add(6, 1'b1, 1'b1); add(2, 1'b1, 1'b0); add(15, 1'b1, 1'b1); add(2, 1'b0, 1'b1);
    // Random phase.
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 3) == 0) hi_len = $urandom_range(8, 12);
      else hi_len = $urandom_range(1, 40);
      add(hi_len, 1'b1, 1'b1);
      add($urandom_range(1, 4), 1'b0, 1'b1);
      if ($urandom_range(0, 15) == 0) add($urandom_range(1, 3), $urandom_range(0, 1), 1'b0);
    end

    @(posedge clk);
    for (int i = 0; i < key_q.size(); i++) begin
      @(negedge clk);
      key_in = key_q[i];
      reset  = rst_q[i];
      cyc    = i;

      // Model: what the edge about to come produces.
      exp_v = 5'b00000;
      if (!rst_q[i]) begin
        press_start = -1;
      end else begin
        exp_v[4] = key_q[i];
        if (press_start < 0) begin
          if (key_q[i]) begin
            exp_v[3]    = 1'b1;
            press_start = i;
          end
        end else begin
          h = i - press_start;
          if (!key_q[i]) begin
            if (h <= LONG_CNT) exp_v[2] = 1'b1;
            press_start = -1;
          end else if (h == LONG_CNT) begin
            exp_v[1] = 1'b1;
          end else begin
`ifdef KEY_REPEAT_EN
            if (h > LONG_CNT && ((h - LONG_CNT) % REPEAT_CNT) == 0) exp_v[0] = 1'b1;
`endif
          end
        end
      end
      cnt_press  += int'(exp_v[3]);
      cnt_short  += int'(exp_v[2]);
      cnt_long   += int'(exp_v[1]);
      cnt_repeat += int'(exp_v[0]);

      @(posedge clk);
      #1;
      obs_v = {key_down, press_pulse, short_pulse, long_pulse, repeat_pulse};
      dut_press  += int'(press_pulse);
      dut_short  += int'(short_pulse);
      dut_long   += int'(long_pulse);
      dut_repeat += int'(repeat_pulse);
      check_value("outs{down,press,short,long,rep}", 32'(obs_v), 32'(exp_v));
    end

    check_value("press_count",  32'(dut_press),  32'(cnt_press));
    check_value("short_count",  32'(dut_short),  32'(cnt_short));
    check_value("long_count",   32'(dut_long),   32'(cnt_long));
    check_value("repeat_count", 32'(dut_repeat), 32'(cnt_repeat));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Sits directly downstream of the 20 ms key debouncer in the clock/stopwatch design. It takes one debounced key level and turns it into single-cycle event pulses: press edge, short press, long press and auto-repeat. The mode/adjust logic uses these pulses for set/increment/start-stop. It replaces the ad-hoc edge detection that was otherwise spread across the time counters.

Parameters:
PRESS_LEVEL, 1'b1, value of key_in that means "pressed" (the debouncer output follows the raw key, so this is board dependent)
LONG_CNT, 50_000_000, hold length in clk cycles before a press counts as long (1 s at 50 MHz); must be >= 2
REPEAT_CNT, 10_000_000, period in clk cycles between auto-repeat pulses after a long press (200 ms at 50 MHz); must be >= 2
CNT_W, 32, width of the internal hold counter; must satisfy 2^CNT_W > max(LONG_CNT, REPEAT_CNT)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous reset, active-low
key_in  input  1  debounced key level, already synchronous to clk
key_down  output  1  registered level, 1 while the key is pressed
press_pulse  output  1  one-cycle pulse on each press edge
short_pulse  output  1  one-cycle pulse on release when the hold was shorter than LONG_CNT
long_pulse  output  1  one-cycle pulse when the hold reaches LONG_CNT (key still down)
repeat_pulse  output  1  one-cycle pulse every REPEAT_CNT cycles while held after long_pulse (KEY_REPEAT_EN only)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hold_cnt=0, key_d=~PRESS_LEVEL, all outputs 0.
- act = (key_in == PRESS_LEVEL). key_d is a one-flop copy of key_in. No extra synchroniser is used; key_in is trusted to be clean.
- All outputs are registered. Every pulse is exactly 1 clk wide and is asserted in the cycle after the clk edge where the causing condition is sampled.
- key_down is act delayed by one cycle.
- States:
  - IDLE: hold_cnt=0. If act, go to PRESSED and assert press_pulse.
  - PRESSED: hold_cnt increments by 1 each cycle.
    - If !act, go to IDLE and assert short_pulse.
    - Else if hold_cnt == LONG_CNT-1, go to HELD, assert long_pulse and clear hold_cnt.
  - HELD:
    - If !act, go to IDLE with no pulse. A long press never produces a short_pulse.
    - Otherwise, behaviour follows the Optional Feature.
- Timing: long_pulse appears exactly LONG_CNT cycles after press_pulse.
- Simultaneous events: if release and hold_cnt == LONG_CNT-1 occur on the same cycle, release wins. The result is short_pulse, with no long_pulse.
- At most one of press_pulse, short_pulse, long_pulse or repeat_pulse is high in any cycle.
- Counter never wraps. It is cleared on every state change and bounded by LONG_CNT-1 or REPEAT_CNT-1.
- Reset mid-hold: returns to IDLE immediately with all pulses 0. If the key is still held when reset is released, a fresh press_pulse follows on the first active cycle. This is intended: a held key after reset counts as a new press.
- Back-to-back presses: after a release, one cycle in IDLE is required. A press sampled in that cycle is accepted normally.

Optional Feature:
Macro KEY_REPEAT_EN.
- Defined: in HELD, hold_cnt increments each cycle while act. At hold_cnt == REPEAT_CNT-1, repeat_pulse is asserted and hold_cnt is cleared. The first repeat comes REPEAT_CNT cycles after long_pulse, with period REPEAT_CNT after that. Release takes priority over a coincident repeat.
- Not defined: the repeat_pulse port still exists and is tied to 0. hold_cnt stays at 0 in HELD, and HELD only waits for release.

Test Plan (PRESS_LEVEL=1, LONG_CNT=10, REPEAT_CNT=4):
1. Reset behaviour: reset=0 for 3 cycles with key_in=1 -> all outputs 0. After reset=1 -> press_pulse on the first following cycle, key_down=1.
2. Short press: key_in high for 5 cycles then low -> press_pulse once, short_pulse once 5 cycles later, long_pulse never, key_down high for 5 cycles.
3. Long press, macro off: key_in high for 30 cycles -> long_pulse exactly 10 cycles after press_pulse, no repeat_pulse, no short_pulse on release.
4. Auto-repeat, KEY_REPEAT_EN defined: key_in high for 30 cycles -> long_pulse at +10, repeat_pulse at +14, +18, +22, +26, none after release.
5. Boundary: release on the exact cycle hold_cnt reaches 9 (high for 10 cycles) -> short_pulse, no long_pulse. High for 11 cycles -> long_pulse, no short_pulse.
6. Reset mid-hold: assert reset at press+6 while key_in stays high, release reset 2 cycles later -> no short_pulse or long_pulse from the aborted hold. A new press_pulse follows, then long_pulse 10 cycles after it.
